// File: rtl/frame_generator_impl.sv
// AXIS Ethernet-style test frame generator: header, sequence number and counting payload.
// Define FRAME_GEN_TIMESTAMP_EN to carry a 64-bit cycle timestamp in bytes 18-25.
module frame_generator_impl #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [10:0]             cfg_len,
  input  logic [31:0]             cfg_count,
  input  logic [15:0]             cfg_gap,
  input  logic [47:0]             cfg_dst_mac,
  input  logic [47:0]             cfg_src_mac,
  input  logic [ID_WIDTH-1:0]     cfg_id,
  output logic [31:0]             frames_sent,
  output logic [47:0]             bytes_sent,
  output logic [DATA_WIDTH-1:0]   axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic                    axis_m_last,
  output logic [DATA_WIDTH/8-1:0] axis_m_user,
  output logic [ID_WIDTH-1:0]     axis_m_id,
  output logic                    axis_m_valid,
  input  logic                    axis_m_ready
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e              state_q, state_d;
  logic [10:0]         len_q;
  logic [31:0]         count_q;
  logic [15:0]         gap_q, gap_cnt_q;
  logic [47:0]         dst_q, src_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [15:0]         base_q;
  logic [31:0]         seq_q, frames_q;
  logic [47:0]         bytes_q;
  logic                stop_q;
`ifdef FRAME_GEN_TIMESTAMP_EN
  logic [63:0]         ts_cnt_q, ts_q;
`endif

  logic        send, beat_fire, last_beat, frame_done, frame_begin, count_hit, start_fire;
  logic [10:0] len_clamped;

  assign send        = (state_q == StSend);
  assign last_beat   = (32'(base_q) + Bytes) >= 32'(len_q);
  assign beat_fire   = send && axis_m_ready;
  assign frame_done  = beat_fire && last_beat;
  assign count_hit   = (count_q != 32'd0) && (frames_q + 32'd1 == count_q);
  assign start_fire  = (state_q == StIdle) && start;
  assign len_clamped = (cfg_len < 11'd60) ? 11'd60 : (cfg_len > 11'd1514) ? 11'd1514 : cfg_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_begin = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSend;
          frame_begin = 1'b1;
        end
      end
      StSend: begin
        // A stop arriving with the last handshake still ends the run here.
        if (frame_done) begin
          if (stop_q || stop || count_hit) state_d = StIdle;
          else if (gap_q != 16'd0)         state_d = StGap;
          else                             frame_begin = 1'b1;
        end
      end
      StGap: begin
        if (stop_q || stop) begin
          state_d = StIdle;
        end else if (gap_cnt_q <= 16'd1) begin
          state_d     = StSend;
          frame_begin = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= 11'd60;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      id_q      <= '0;
      base_q    <= '0;
      seq_q     <= '0;
      frames_q  <= '0;
      bytes_q   <= '0;
      stop_q    <= 1'b0;
    end else begin
      if (start_fire) begin
        len_q    <= len_clamped;
        count_q  <= cfg_count;
        gap_q    <= cfg_gap;
        dst_q    <= cfg_dst_mac;
        src_q    <= cfg_src_mac;
        id_q     <= cfg_id;
        seq_q    <= '0;
        frames_q <= '0;
        bytes_q  <= '0;
        stop_q   <= 1'b0;
      end else begin
        if (stop && state_q != StIdle) stop_q <= 1'b1;
        if (frame_done) begin
          frames_q <= frames_q + 32'd1;
          bytes_q  <= bytes_q + 48'(len_q);
          seq_q    <= seq_q + 32'd1;
        end
      end
      if (frame_done)            gap_cnt_q <= gap_q;
      else if (state_q == StGap) gap_cnt_q <= gap_cnt_q - 16'd1;
      if (frame_begin)           base_q <= '0;
      else if (beat_fire)        base_q <= base_q + 16'(Bytes);
    end
  end

`ifdef FRAME_GEN_TIMESTAMP_EN
  // Captured as the first beat is presented so the beat stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 64'd1;
      if (frame_begin) ts_q <= ts_cnt_q;
    end
  end
`endif

  function automatic logic [7:0] frame_byte(input logic [15:0] idx);
    int k;
    logic [7:0] b;
    k = int'(idx);
    b = idx[7:0];
    if (k < 6)        b = 8'(dst_q >> (8 * (5 - k)));
    else if (k < 12)  b = 8'(src_q >> (8 * (11 - k)));
    else if (k == 12) b = 8'h88;
    else if (k == 13) b = 8'hB5;
    else if (k < 18)  b = 8'(seq_q >> (8 * (17 - k)));
`ifdef FRAME_GEN_TIMESTAMP_EN
    else if (k < 26)  b = 8'(ts_q >> (8 * (25 - k)));
`endif
    return b;
  endfunction

  always_comb begin
    axis_m_data = '0;
    axis_m_keep = '0;
    for (int unsigned i = 0; i < Bytes; i++) begin
      logic [15:0] idx;
      idx = base_q + 16'(i);
      if (send && idx < 16'(len_q)) begin
        axis_m_keep[i]       = 1'b1;
        axis_m_data[8*i +: 8] = frame_byte(idx);
      end
    end
  end

  assign ready        = (state_q == StIdle);
  assign axis_m_valid = send;
  assign axis_m_last  = send && last_beat;
  assign axis_m_user  = '0;
  assign axis_m_id    = send ? id_q : '0;
  assign frames_sent  = frames_q;
  assign bytes_sent   = bytes_q;

endmodule
